// File: rtl/aes_pkg.sv
// aes_pkg: shared AES constants, S-box tables and FSM encoding
package aes_pkg;
  localparam int AES_BLOCK_W = 128;
  localparam logic MODE_ENC = 1'b0;
  localparam logic MODE_DEC = 1'b1;
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d};
endpackage

// File: rtl/aes_sbox.sv
// aes_sbox: combinational forward/inverse AES S-box lookup
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] d,
  input  logic       inv,
  output logic [7:0] q
);
  assign q = (inv == MODE_DEC) ? INV_SBOX[d] : SBOX[d];
endmodule

// File: rtl/sub_bytes_iter.sv
// sub_bytes_iter: iterative AES SubBytes/InvSubBytes, LANES bytes per cycle
module sub_bytes_iter
  import aes_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic [AES_BLOCK_W-1:0] i_data,
  input  logic                   i_mode,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [AES_BLOCK_W-1:0] o_data
);
  localparam int STEPS = 16 / LANES;
  localparam int CW = (STEPS > 1) ? $clog2(STEPS) : 1;
  if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_bad_lanes
    $error("sub_bytes_iter: LANES must be 1, 2, 4, 8 or 16");
  end
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [0:15][7:0] buf_q, buf_d;
  logic mode_q;
  logic [3:0] base;
  logic last;
  logic [7:0] sb_out [LANES];
  assign base = 4'(cnt_q * LANES);
  assign last = cnt_q == CW'(STEPS - 1);
  assign o_ready = state_q == IDLE;
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    aes_sbox u_sbox (.d(buf_q[base + 4'(g)]), .inv(mode_q), .q(sb_out[g]));
  end
  // lanes overwrite their bytes in place; the rest of the buffer passes through
  always_comb begin
    buf_d = buf_q;
    for (int l = 0; l < LANES; l++) buf_d[base + 4'(l)] = sb_out[l];
  end
  always_comb begin
    state_d = (state_q == IDLE) ? (i_valid ? BUSY : IDLE) :
              (state_q == BUSY) ? (last ? DONE : BUSY) :
              (state_q == DONE) ? (i_ready ? IDLE : DONE) : IDLE;
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      buf_q   <= '0;
      mode_q  <= MODE_ENC;
      o_valid <= 1'b0;
      o_data  <= '0;
    end else begin
      state_q <= state_d;
      o_valid <= state_d == DONE;
      if (state_q == IDLE && i_valid) begin
        buf_q  <= i_data;
        mode_q <= i_mode;
        cnt_q  <= '0;
      end
      if (state_q == BUSY) begin
        buf_q <= buf_d;
        cnt_q <= cnt_q + 1'b1;
        if (last) o_data <= buf_d;
      end
    end
  end
endmodule

// File: tb/tb_sub_bytes_iter.sv
// tb_sub_bytes_iter: directed-vector self-checking bench for sub_bytes_iter
module tb_sub_bytes_iter;
  localparam logic [127:0] V1 = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] E1 = 128'hd42711aee0bf98f1b8b45de51e415230;
  localparam int LV[5] = '{4, 1, 2, 8, 16};
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [4:0] v = '0;
  logic [4:0] ir = '0;
  logic [4:0] ov, rdy;
  logic [127:0] od [5];
  logic [127:0] idata = '0;
  logic imode = 1'b0;
  int ntests = 0;
  int nfail = 0;
  always #5 clk = ~clk;
  for (genvar k = 0; k < 5; k++) begin : g_dut
    sub_bytes_iter #(.LANES(LV[k])) u_dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_valid(v[k]), .o_ready(rdy[k]),
      .i_data(idata), .i_mode(imode), .o_valid(ov[k]), .i_ready(ir[k]), .o_data(od[k]));
  end
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    ntests++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  // accept one block, scramble inputs during BUSY, then measure latency and result
  task automatic run(input int k, input logic [127:0] d, input logic m, input logic [127:0] exp,
                     input string tag);
    int lat;
    @(negedge clk);
    idata = d;
    imode = m;
    v[k] = 1'b1;
    @(negedge clk);
    v[k] = 1'b0;
    idata = ~d;
    imode = ~m;
    lat = 0;
    while (!ov[k] && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_lat"}, 128'(lat), 128'(16 / LV[k]));
    check({tag, "_data"}, od[k], exp);
    check({tag, "_rdy"}, {127'd0, rdy[k]}, 128'd0);
  endtask
  task automatic release_out(input int k, input string tag);
    @(negedge clk);
    v[k] = 1'b0;
    ir[k] = 1'b1;
    @(negedge clk);
    ir[k] = 1'b0;
    check({tag, "_rel"}, {126'd0, ov[k], rdy[k]}, 128'b01);
  endtask
  task automatic tput(input int k, input string tag);
    int cyc, r;
    int t[2];
    logic prev;
    t = '{0, 0};
    @(negedge clk);
    idata = V1;
    imode = 1'b0;
    v[k] = 1'b1;
    ir[k] = 1'b1;
    cyc = 0;
    r = 0;
    prev = ov[k];
    while (r < 2 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (ov[k] && !prev) begin
        t[r] = cyc;
        r++;
      end
      prev = ov[k];
    end
    check({tag, "_tput"}, 128'(t[1] - t[0]), 128'(16 / LV[k] + 2));
    check({tag, "_tdata"}, od[k], E1);
    v[k] = 1'b0;
    repeat (40) @(negedge clk);
    ir[k] = 1'b0;
  endtask
  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_state", {126'd0, ov[0], rdy[0]}, 128'b01);
    check("rst_data", od[0], 128'd0);
    rst_n = 1'b1;
    run(0, V1, 1'b0, E1, "fips_fwd");
    release_out(0, "fips_fwd");
    run(0, E1, 1'b1, V1, "fips_inv");
    release_out(0, "fips_inv");
    run(0, {16{8'h63}}, 1'b1, 128'd0, "inv_63");
    release_out(0, "inv_63");
    run(0, 128'd0, 1'b0, {16{8'h63}}, "fwd_00");
    release_out(0, "fwd_00");
    run(0, {16{8'hff}}, 1'b0, {16{8'h16}}, "fwd_ff");
    release_out(0, "fwd_ff");
    run(0, {16{8'h53}}, 1'b0, {16{8'hed}}, "fwd_53");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      v[0] = i[0];
      idata = ~V1;
      check("bp_data", od[0], {16{8'hed}});
      check("bp_flags", {126'd0, ov[0], rdy[0]}, 128'b10);
    end
    release_out(0, "bp");
    @(negedge clk);
    idata = 128'h0123456789abcdef0011223344556677;
    imode = 1'b0;
    v[0] = 1'b1;
    repeat (3) @(negedge clk) v[0] = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_flags", {126'd0, ov[0], rdy[0]}, 128'b01);
    check("midrst_data", od[0], 128'd0);
    rst_n = 1'b1;
    run(0, V1, 1'b0, E1, "post_rst");
    release_out(0, "post_rst");
    tput(0, "l4");
    for (int k = 1; k < 5; k++) begin
      run(k, V1, 1'b0, E1, $sformatf("l%0d", LV[k]));
      release_out(k, $sformatf("l%0d", LV[k]));
      tput(k, $sformatf("l%0d", LV[k]));
    end
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
